bs_price: RTL and testbench
===========================

BS_PRICE -- requirements
Module: bs_price

Interface
REQ-001 SHALL have parameter: WIDTH, 32, signed fixed-point word width; all data is Q16.16.
REQ-002 SHALL have ports, in this order:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; samples the operand inputs.
- s_in  input  WIDTH  spot price S, signed Q16.16.
- kd_in  input  WIDTH  discounted strike K*exp(-rT), signed Q16.16.
- d1_in  input  WIDTH  d1, signed Q16.16.
- d2_in  input  WIDTH  d2, signed Q16.16.
- n_start  output  1  one-cycle request to the CDF stage.
- n_d  output  WIDTH  argument for the CDF stage.
- n_value  input  WIDTH  N(n_d) from the CDF stage, Q16.16 in [0, 1.0].
- n_done  input  1  one-cycle CDF completion strobe.
- call_out  output  WIDTH  call price, Q16.16.
- put_out  output  WIDTH  put price, Q16.16.
- busy  output  1  high from the start acceptance until done.
- done  output  1  one-cycle result-valid strobe.

Function
REQ-003 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect on the operation in flight.
REQ-004 SHALL latch s_in, kd_in, d1_in and d2_in on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-005 SHALL sequence through these states: IDLE -> REQ1 -> WAIT1 -> REQ2 -> WAIT2 -> MUL_A -> MUL_B -> DONE -> IDLE.
REQ-006 In REQ1 and REQ2, SHALL drive n_start high for exactly one cycle, with n_d = latched d1 and d2 respectively.
REQ-007 n_d SHALL hold its value from the REQ cycle until the matching n_done.
REQ-008 SHALL capture n_value into N1 on n_done in WAIT1 and into N2 on n_done in WAIT2.
REQ-009 n_done in any state other than WAIT1 or WAIT2 SHALL be ignored.
REQ-010 SHALL wait indefinitely in WAIT1/WAIT2; there is no timeout.
REQ-011 MUL_A SHALL compute the products S*N1 and Kd*N2.
REQ-012 MUL_B SHALL compute S*(1.0-N1) and Kd*(1.0-N2).
REQ-013 Each product SHALL be a 64-bit signed product with result bits [47:16] taken (truncation).
REQ-014 call = S*N1 - Kd*N2; put = Kd*(1-N2) - S*(1-N1). Both differences SHALL be formed at WIDTH+1 bits.
REQ-015 A negative result SHALL clamp to 0; a result above 0x7FFFFFFF SHALL saturate to 0x7FFFFFFF.
REQ-016 In DONE, SHALL register call_out and put_out, pulse done for one cycle, and return to IDLE on the next edge.
REQ-017 call_out and put_out SHALL hold until the next DONE. busy SHALL fall in the same cycle that done rises.
REQ-018 Latency from the start edge to done SHALL be 6 cycles plus the cycles spent in WAIT1 and WAIT2.
REQ-019 start may be asserted in the cycle after done and SHALL be accepted.

Reset
REQ-020 reset_n low SHALL immediately force: state IDLE; n_start, busy and done = 0; n_d, call_out and put_out = 0; N1, N2 and the latched operands = 0.
REQ-021 Reset asserted mid-operation SHALL abandon the operation. No done SHALL follow, and a late n_done after release SHALL be ignored (IDLE).
REQ-022 Release of reset SHALL take effect at the first rising clk edge with reset_n high.

Structure
REQ-023 A shared package SHALL hold the Q16.16 constants (ONE = 0x00010000, ZERO, SAT_MAX = 0x7FFFFFFF) and the state encoding.
REQ-024 One sub-module SHALL be used: q16_mul, combinational signed WIDTH x WIDTH -> [47:16], instantiated twice and shared by MUL_A and MUL_B.
REQ-025 The block SHALL connect directly to the existing CDF stage. Map n_start/n_d to its start/d, n_value/n_done to its N/done, and drive that stage's active-high reset from the inverse of reset_n.

Verification
REQ-026 The bench SHALL cover these scenarios:
- S=100.0 (0x00640000), Kd=100.0, d1=d2=0 with CDF model returning 0x8000 -> call_out=0, put_out=0, done after 6+wait cycles.
- S=100.0, Kd=90.0, d1=d2=3.0 with N=0x00010000 -> call_out=0x000A0000, put_out=0.
- S=100.0, Kd=110.0, d1=d2=-3.0 with N=0 -> call_out=0, put_out=0x000A0000; a second scenario with Kd=90.0 -> put clamps to 0.
- start re-pulsed in WAIT1 and in WAIT2 -> ignored; exactly one n_start per REQ state, exactly one done.
- reset_n pulsed low during WAIT2, then a stray n_done -> outputs 0, no done, busy=0, state IDLE.
- n_done delayed 0, 1 and 20 cycles -> results identical; n_d stable until n_done; back-to-back start accepted the cycle after done.

Source files
------------

// File: rtl/bs_price_pkg.sv
// bs_price_pkg: shared Q16.16 constants and the pricing FSM state encoding.
//   ONE     : 1.0 in Q16.16
//   ZERO    : 0.0 in Q16.16
//   SAT_MAX : largest positive Q16.16 word
//   state_t : bs_price controller states, in sequencing order
package bs_price_pkg;

  localparam logic signed [31:0] ONE     = 32'sh0001_0000;
  localparam logic signed [31:0] ZERO    = 32'sh0000_0000;
  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ1  = 3'd1,
    ST_WAIT1 = 3'd2,
    ST_REQ2  = 3'd3,
    ST_WAIT2 = 3'd4,
    ST_MUL_A = 3'd5,
    ST_MUL_B = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/bs_price_mul.sv
// q16_mul: combinational signed Q16.16 multiply.
//   i_a, i_b : signed Q16.16 operands
//   o_p      : bits [47:16] of the full signed product (truncated, i.e. floor)
module q16_mul #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  logic signed [2*WIDTH-1:0] w_full;
  logic                      w_unused_bits;

  assign w_full = i_a * i_b;
  assign o_p    = w_full[WIDTH+15:16];

  // Integer overflow bits and sub-LSB fraction are discarded by design.
  assign w_unused_bits = ^{w_full[2*WIDTH-1:WIDTH+16], w_full[15:0]};

endmodule

// File: rtl/bs_price.sv
// bs_price: Black-Scholes call/put pricing from precomputed d1/d2.
// Requests N(d1) and N(d2) from an external CDF stage, then forms
//   call = S*N1 - Kd*N2
//   put  = Kd*(1-N2) - S*(1-N1)
// with results clamped to [0, 0x7FFFFFFF]. All data is signed Q16.16.
// The CDF stage connects directly: n_start/n_d -> its start/d,
// its N/done -> n_value/n_done, and its active-high reset is ~reset_n.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle request, accepted only when idle
//   s_in, kd_in           : spot price, discounted strike
//   d1_in, d2_in          : CDF arguments
//   n_start, n_d          : CDF request strobe and argument
//   n_value, n_done       : CDF result and completion strobe
//   call_out, put_out     : prices, held until the next completion
//   busy, done            : in-flight flag, one-cycle result strobe
module bs_price
  import bs_price_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] s_in,
  input  logic signed [WIDTH-1:0] kd_in,
  input  logic signed [WIDTH-1:0] d1_in,
  input  logic signed [WIDTH-1:0] d2_in,
  output logic                    n_start,
  output logic signed [WIDTH-1:0] n_d,
  input  logic signed [WIDTH-1:0] n_value,
  input  logic                    n_done,
  output logic signed [WIDTH-1:0] call_out,
  output logic signed [WIDTH-1:0] put_out,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] W_ONE = WIDTH'(ONE);
  localparam logic signed [WIDTH-1:0] W_MAX = WIDTH'(SAT_MAX);
  localparam logic signed [WIDTH-1:0] W_ZERO = WIDTH'(ZERO);

  // Clamp a WIDTH+1 bit difference into [0, max positive WIDTH word].
  function automatic logic signed [WIDTH-1:0] sat_pos(input logic signed [WIDTH:0] x);
    logic signed [WIDTH-1:0] r;
    if (x[WIDTH]) begin
      r = W_ZERO;
    end else if (x[WIDTH-1]) begin
      r = W_MAX;
    end else begin
      r = x[WIDTH-1:0];
    end
    return r;
  endfunction

  state_t r_state;
  state_t w_next;

  logic signed [WIDTH-1:0] r_s;
  logic signed [WIDTH-1:0] r_kd;
  logic signed [WIDTH-1:0] r_d2;
  logic signed [WIDTH-1:0] r_n1;
  logic signed [WIDTH-1:0] r_n2;
  logic signed [WIDTH-1:0] r_p_sn1;
  logic signed [WIDTH-1:0] r_p_kn2;

  logic signed [WIDTH-1:0] w_b0;
  logic signed [WIDTH-1:0] w_b1;
  logic signed [WIDTH-1:0] w_p0;
  logic signed [WIDTH-1:0] w_p1;
  logic signed [WIDTH:0]   w_call_diff;
  logic signed [WIDTH:0]   w_put_diff;
  logic                    w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

  // Two multipliers shared between MUL_A (N) and MUL_B (1-N).
  assign w_b0 = (r_state == ST_MUL_A) ? r_n1 : (W_ONE - r_n1);
  assign w_b1 = (r_state == ST_MUL_A) ? r_n2 : (W_ONE - r_n2);

  q16_mul #(.WIDTH(WIDTH)) u_mul_s (
    .i_a (r_s),
    .i_b (w_b0),
    .o_p (w_p0)
  );

  q16_mul #(.WIDTH(WIDTH)) u_mul_kd (
    .i_a (r_kd),
    .i_b (w_b1),
    .o_p (w_p1)
  );

  // Call uses the MUL_A products held in registers; put uses the live
  // MUL_B products. Sign extension keeps both differences exact.
  assign w_call_diff = {r_p_sn1[WIDTH-1], r_p_sn1} - {r_p_kn2[WIDTH-1], r_p_kn2};
  assign w_put_diff  = {w_p1[WIDTH-1], w_p1} - {w_p0[WIDTH-1], w_p0};

  always_comb begin
    w_next  = r_state;
    n_start = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_REQ1;
      ST_REQ1:  begin
        n_start = 1'b1;
        w_next  = ST_WAIT1;
      end
      ST_WAIT1: if (n_done) w_next = ST_REQ2;
      ST_REQ2:  begin
        n_start = 1'b1;
        w_next  = ST_WAIT2;
      end
      ST_WAIT2: if (n_done) w_next = ST_MUL_A;
      ST_MUL_A: w_next = ST_MUL_B;
      ST_MUL_B: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Both flags follow the next state so busy drops as done rises.
      busy    <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      done    <= (w_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s      <= '0;
      r_kd     <= '0;
      r_d2     <= '0;
      r_n1     <= '0;
      r_n2     <= '0;
      r_p_sn1  <= '0;
      r_p_kn2  <= '0;
      n_d      <= '0;
      call_out <= '0;
      put_out  <= '0;
    end else begin
      if (w_accept) begin
        r_s  <= s_in;
        r_kd <= kd_in;
        r_d2 <= d2_in;
        // d1 goes straight to n_d so it is valid in the REQ1 cycle.
        n_d  <= d1_in;
      end
      if ((r_state == ST_WAIT1) && n_done) begin
        r_n1 <= n_value;
        n_d  <= r_d2;
      end
      if ((r_state == ST_WAIT2) && n_done) begin
        r_n2 <= n_value;
      end
      if (r_state == ST_MUL_A) begin
        r_p_sn1 <= w_p0;
        r_p_kn2 <= w_p1;
      end
      if (r_state == ST_MUL_B) begin
        call_out <= sat_pos(w_call_diff);
        put_out  <= sat_pos(w_put_diff);
      end
    end
  end

endmodule

// File: tb/tb_bs_price.sv
module tb_bs_price;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  s_in = '0;
  logic [WIDTH-1:0]  kd_in = '0;
  logic [WIDTH-1:0]  d1_in = '0;
  logic [WIDTH-1:0]  d2_in = '0;
  logic              n_start;
  logic [WIDTH-1:0]  n_d;
  logic [WIDTH-1:0]  n_value = '0;
  logic              n_done = 1'b0;
  logic [WIDTH-1:0]  call_out;
  logic [WIDTH-1:0]  put_out;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  bs_price #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .s_in     (s_in),
    .kd_in    (kd_in),
    .d1_in    (d1_in),
    .d2_in    (d2_in),
    .n_start  (n_start),
    .n_d      (n_d),
    .n_value  (n_value),
    .n_done   (n_done),
    .call_out (call_out),
    .put_out  (put_out),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    string       name;
    logic [31:0] s;
    logic [31:0] kd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] n1;
    logic [31:0] n2;
    int          delay;
    bit          repulse;
    logic [31:0] call;
    logic [31:0] put;
  } vec_t;

  typedef struct {
    logic [31:0] call;
    logic [31:0] put;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  // Runs one pricing operation, acting as the CDF stage with the given delay.
  task automatic run_op(input vec_t v);
    int          cyc;
    int          pend;
    int          nreq;
    bit          fin;
    logic [31:0] exp_nd;
    exp_t        e;
    @(negedge clk);
    chk({v.name, ":done_before_start"}, {31'b0, done}, 32'd0);
    start = 1'b1;
    s_in  = v.s;
    kd_in = v.kd;
    d1_in = v.d1;
    d2_in = v.d2;
    sb_q.push_back('{call: v.call, put: v.put});
    cyc = 0; pend = -1; nreq = 0; fin = 1'b0; exp_nd = '0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      s_in    = $urandom;
      kd_in   = $urandom;
      d1_in   = $urandom;
      d2_in   = $urandom;
      n_done  = 1'b0;
      n_value = $urandom;
      if (cyc == 1) chk({v.name, ":busy_after_accept"}, {31'b0, busy}, 32'd1);
      if (pend == 0) begin
        n_done  = 1'b1;
        n_value = (nreq == 1) ? v.n1 : v.n2;
        chk({v.name, ":n_d_at_n_done"}, n_d, exp_nd);
        pend = -1;
      end else if (pend > 0) begin
        if (n_d !== exp_nd) chk({v.name, ":n_d_hold"}, n_d, exp_nd);
        pend--;
        if (v.repulse) start = 1'b1;
      end
      if (n_start) begin
        nreq++;
        exp_nd = (nreq == 1) ? v.d1 : v.d2;
        chk({v.name, ":n_d_at_req"}, n_d, exp_nd);
        pend = v.delay;
      end
      if (done) begin
        fin = 1'b1;
        chk({v.name, ":latency"}, 32'(cyc - 1), 32'(6 + 2 * v.delay));
        chk({v.name, ":busy_at_done"}, {31'b0, busy}, 32'd0);
        chk({v.name, ":n_start_count"}, 32'(nreq), 32'd2);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s:scoreboard actual=done required=expected_entry", v.name);
        end else begin
          e = sb_q.pop_front();
          chk({v.name, ":call_out"}, call_out, e.call);
          chk({v.name, ":put_out"}, put_out, e.put);
        end
      end
    end
    start = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s:timeout actual=no_done required=done", v.name);
      sb_q.delete();
    end
  endtask

  // Idle cycles after an operation: outputs hold, no stray strobes.
  task automatic idle_check(input string name, input logic [31:0] c, input logic [31:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, ":idle_done"}, {31'b0, done}, 32'd0);
      chk({name, ":idle_n_start"}, {31'b0, n_start}, 32'd0);
      chk({name, ":idle_busy"}, {31'b0, busy}, 32'd0);
      chk({name, ":call_hold"}, call_out, c);
      chk({name, ":put_hold"}, put_out, p);
    end
  endtask

  initial begin
    int nreq;
    int guard;
    vec_t rp;

    //          name          s             kd            d1            d2            n1            n2         dly rp call          put
    vecs[0]  = '{"atm_d0",   32'h00640000, 32'h00640000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00008000, 0, 0, 32'h00000000, 32'h00000000};
    vecs[1]  = '{"atm_d1",   32'h00640000, 32'h00640000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00008000, 1, 0, 32'h00000000, 32'h00000000};
    vecs[2]  = '{"atm_d20",  32'h00640000, 32'h00640000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00008000, 20, 0, 32'h00000000, 32'h00000000};
    vecs[3]  = '{"itm_call", 32'h00640000, 32'h005A0000, 32'h00030000, 32'h00030000, 32'h00010000, 32'h00010000, 0, 0, 32'h000A0000, 32'h00000000};
    vecs[4]  = '{"itm_put",  32'h00640000, 32'h006E0000, 32'hFFFD0000, 32'hFFFD0000, 32'h00000000, 32'h00000000, 1, 0, 32'h00000000, 32'h000A0000};
    vecs[5]  = '{"put_clamp",32'h00640000, 32'h005A0000, 32'hFFFD0000, 32'hFFFD0000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 32'h00000000};
    vecs[6]  = '{"mixed",    32'h00640000, 32'h005A0000, 32'h00010000, 32'h00008000, 32'h0000C000, 32'h00004000, 2, 0, 32'h00348000, 32'h002A8000};
    vecs[7]  = '{"saturate", 32'h7FFFFFFF, 32'h80000000, 32'h00050000, 32'h00050000, 32'h00010000, 32'h00010000, 0, 0, 32'h7FFFFFFF, 32'h00000000};
    vecs[8]  = '{"trunc_pos",32'h00010001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00000000, 0, 0, 32'h00008000, 32'h00000000};
    vecs[9]  = '{"trunc_neg",32'hFFFEFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00008000, 32'h00000000, 3, 0, 32'h00000000, 32'h00008001};
    vecs[10] = '{"repulse",  32'h00640000, 32'h005A0000, 32'h00030000, 32'h00030000, 32'h00010000, 32'h00010000, 2, 1, 32'h000A0000, 32'h00000000};
    vecs[11] = '{"post_rst", 32'h00640000, 32'h006E0000, 32'hFFFD0000, 32'hFFFD0000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 32'h000A0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst:busy", {31'b0, busy}, 32'd0);
    chk("rst:done", {31'b0, done}, 32'd0);
    chk("rst:n_start", {31'b0, n_start}, 32'd0);
    chk("rst:n_d", n_d, 32'd0);
    chk("rst:call_out", call_out, 32'd0);
    chk("rst:put_out", put_out, 32'd0);
    reset_n = 1'b1;

    // Table-driven operations, each started the cycle after the previous done
    for (int i = 0; i < 10; i++) run_op(vecs[i]);
    idle_check("after_table", 32'h00000000, 32'h00008001, 3);

    // start re-pulsed during both WAIT states must be ignored
    run_op(vecs[10]);
    idle_check("after_repulse", 32'h000A0000, 32'h00000000, 4);

    // Reset during WAIT2 abandons the operation; a late n_done is ignored
    rp = vecs[3];
    @(negedge clk);
    start = 1'b1; s_in = rp.s; kd_in = rp.kd; d1_in = rp.d1; d2_in = rp.d2;
    nreq = 0; guard = 0;
    while (nreq < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      start  = 1'b0;
      n_done = 1'b0;
      if (n_start) begin
        nreq++;
        if (nreq == 1) begin
          @(negedge clk);
          n_done = 1'b1; n_value = rp.n1;
        end
      end
    end
    chk("rst_mid:reached_req2", 32'(nreq), 32'd2);
    n_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid:busy_in_wait2", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid:busy", {31'b0, busy}, 32'd0);
    chk("rst_mid:done", {31'b0, done}, 32'd0);
    chk("rst_mid:n_start", {31'b0, n_start}, 32'd0);
    chk("rst_mid:n_d", n_d, 32'd0);
    chk("rst_mid:call_out", call_out, 32'd0);
    chk("rst_mid:put_out", put_out, 32'd0);
    chk("rst_mid:state", 32'(dut.r_state), 32'(bs_price_pkg::ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_done = 1'b1; n_value = 32'h00010000;
    @(negedge clk);
    n_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_mid:no_done", {31'b0, done}, 32'd0);
      chk("rst_mid:no_busy", {31'b0, busy}, 32'd0);
      if (n_start !== 1'b0) chk("rst_mid:no_n_start", {31'b0, n_start}, 32'd0);
      @(negedge clk);
    end
    chk("rst_mid:state_after", 32'(dut.r_state), 32'(bs_price_pkg::ST_IDLE));
    chk("rst_mid:call_after", call_out, 32'd0);
    sb_q.delete();

    // Normal operation after the abandoned one
    run_op(vecs[11]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
